// File: rtl/lfu_replacement_unit.sv
// ---------------------------------------------------------------------------
// lfu_replacement_unit
//
// LFU replacement engine for a set-associative cache controller. Keeps one
// saturating access counter for every (set, way) pair and answers
// "which way of this set is least frequently used" queries. Counters are
// updated by touch/fill/clear requests; a touch on a saturated counter ages
// the whole set (every counter halved) so old history fades out. A flush
// pulse walks through every set and zeroes it, one set per cycle.
//
// Ports
//   clk          rising-edge clock
//   gen_reset_n  asynchronous active-low reset, clears counters and control
//   flush        one-cycle pulse, starts the whole-array zeroing sequence
//   req_valid    request present
//   req_ready    request accepted when req_valid & req_ready
//   req_op       00 touch, 01 fill, 10 victim query, 11 clear set
//   req_set      target set index
//   req_way      target way (ignored for victim and clear)
//   rsp_valid    one-cycle pulse, victim result valid
//   rsp_way      least-frequently-used way of the queried set
//   rsp_count    counter value of rsp_way when the query was accepted
//   flush_busy   flush sequence in progress
// ---------------------------------------------------------------------------
module lfu_replacement_unit #(
    parameter int WAYS     = 4,
    parameter int SET_BITS = 10,
    parameter int CNT_W    = 4,
    parameter int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                clk,
    input  logic                gen_reset_n,
    input  logic                flush,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [SET_BITS-1:0] req_set,
    input  logic [WAY_W-1:0]    req_way,
    output logic                rsp_valid,
    output logic [WAY_W-1:0]    rsp_way,
    output logic [CNT_W-1:0]    rsp_count,
    output logic                flush_busy
);

    localparam int NUM_SETS = 1 << SET_BITS;

    localparam logic [1:0] OP_TOUCH  = 2'b00;
    localparam logic [1:0] OP_FILL   = 2'b01;
    localparam logic [1:0] OP_VICTIM = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
    // (MAX >> 1) + 1 is simply the counter's top bit on its own.
    localparam logic [CNT_W-1:0]    CNT_AGED = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [SET_BITS-1:0] PTR_LAST = '1;

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [SET_BITS-1:0] r_flushPtr;

    logic [CNT_W-1:0]    r_cnt [NUM_SETS][WAYS];

    logic [CNT_W-1:0]    w_rowCur  [WAYS];
    logic [CNT_W-1:0]    w_rowNext [WAYS];
    logic                w_wayHit;
    logic [CNT_W-1:0]    w_targetCnt;
    logic                w_accept;
    logic                w_wrEn;
    logic [WAY_W-1:0]    w_vicWay;
    logic [CNT_W-1:0]    w_vicCnt;

    logic                r_rspValid;
    logic [WAY_W-1:0]    r_rspWay;
    logic [CNT_W-1:0]    r_rspCount;

    // A flush request in the same cycle blocks acceptance, so flush wins.
    assign req_ready  = (r_state == ST_IDLE) && !flush;
    assign w_accept   = req_valid && req_ready;
    assign w_wrEn     = w_accept && (req_op != OP_VICTIM);
    assign flush_busy = (r_state == ST_FLUSH);
    assign rsp_valid  = r_rspValid;
    assign rsp_way    = r_rspWay;
    assign rsp_count  = r_rspCount;

    always_ff @(posedge clk or negedge gen_reset_n) begin
        if (!gen_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Flush is not re-armed while already flushing; the sequence ends once
    // the last set index has been zeroed.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: begin
                if (flush) begin
                    w_stateNext = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (r_flushPtr == PTR_LAST) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // The pointer sits at zero while idle, so entering FLUSH always starts
    // at set 0; it wraps back to zero naturally after the last set.
    always_ff @(posedge clk or negedge gen_reset_n) begin
        if (!gen_reset_n) begin
            r_flushPtr <= '0;
        end else if (r_state == ST_FLUSH) begin
            r_flushPtr <= r_flushPtr + SET_BITS'(1);
        end else begin
            r_flushPtr <= '0;
        end
    end

    // Read the addressed set and locate the target way. Matching by loop
    // keeps an out-of-range way index from touching any counter.
    always_comb begin
        w_wayHit    = 1'b0;
        w_targetCnt = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_rowCur[w] = r_cnt[req_set][w];
            if (req_way == WAY_W'(w)) begin
                w_wayHit    = 1'b1;
                w_targetCnt = r_cnt[req_set][w];
            end
        end
    end

    // New contents of the addressed set for touch, fill and clear.
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            w_rowNext[w] = w_rowCur[w];
        end
        case (req_op)
            OP_TOUCH: begin
                if (w_wayHit && (w_targetCnt == CNT_MAX)) begin
                    for (int w = 0; w < WAYS; w++) begin
                        w_rowNext[w] = w_rowCur[w] >> 1;
                        if (req_way == WAY_W'(w)) begin
                            w_rowNext[w] = CNT_AGED;
                        end
                    end
                end else begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (req_way == WAY_W'(w)) begin
                            w_rowNext[w] = w_rowCur[w] + CNT_ONE;
                        end
                    end
                end
            end
            OP_FILL: begin
                for (int w = 0; w < WAYS; w++) begin
                    if (req_way == WAY_W'(w)) begin
                        w_rowNext[w] = CNT_ONE;
                    end
                end
            end
            OP_CLEAR: begin
                for (int w = 0; w < WAYS; w++) begin
                    w_rowNext[w] = '0;
                end
            end
            default: ;
        endcase
    end

    // Minimum search; strict less-than keeps the lowest way on ties.
    always_comb begin
        w_vicWay = '0;
        w_vicCnt = w_rowCur[0];
        for (int w = 1; w < WAYS; w++) begin
            if (w_rowCur[w] < w_vicCnt) begin
                w_vicWay = WAY_W'(w);
                w_vicCnt = w_rowCur[w];
            end
        end
    end

    // Counter array: flush zeroes one set per cycle, otherwise an accepted
    // update rewrites the addressed set. The two never coincide because
    // requests are refused while flushing.
    always_ff @(posedge clk or negedge gen_reset_n) begin
        if (!gen_reset_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_cnt[s][w] <= '0;
                end
            end
        end else if (r_state == ST_FLUSH) begin
            for (int w = 0; w < WAYS; w++) begin
                r_cnt[r_flushPtr][w] <= '0;
            end
        end else if (w_wrEn) begin
            for (int w = 0; w < WAYS; w++) begin
                r_cnt[req_set][w] <= w_rowNext[w];
            end
        end
    end

    // Victim response is registered from the accept-cycle array contents;
    // way/count hold their last result between queries.
    always_ff @(posedge clk or negedge gen_reset_n) begin
        if (!gen_reset_n) begin
            r_rspValid <= 1'b0;
            r_rspWay   <= '0;
            r_rspCount <= '0;
        end else begin
            r_rspValid <= w_accept && (req_op == OP_VICTIM);
            if (w_accept && (req_op == OP_VICTIM)) begin
                r_rspWay   <= w_vicWay;
                r_rspCount <= w_vicCnt;
            end
        end
    end

endmodule
